// File: rtl/redmule_pkg.sv
// redmule_pkg
// Shared types for the RedMulE Z-buffer scheduler:
//   zbuf_state_e : scheduler state (IDLE, FILL, DRAIN)
//   zbuf_flgs_t  : registered buffer status flags (full, empty)
package redmule_pkg;

    typedef enum logic [1:0] {
        ZBUF_IDLE  = 2'd0,
        ZBUF_FILL  = 2'd1,
        ZBUF_DRAIN = 2'd2
    } zbuf_state_e;

    typedef struct packed {
        logic full;
        logic empty;
    } zbuf_flgs_t;

endpackage

// File: rtl/redmule_row_counter.sv
// redmule_row_counter
// Up-counter that wraps to zero after reaching limit_i-1.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear (priority over en_i)
//   en_i          : count enable
//   limit_i       : number of rows before wrapping (must be >= 1)
//   cnt_o         : current count (registered)
//   wrap_o        : en_i on the last row, i.e. this edge wraps to zero
module redmule_row_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_r;
    logic             last_s;

    // Detect the last row and the wrap strobe.
    always_comb begin
        last_s = (cnt_r == (limit_i - WIDTH'(1)));
        wrap_o = en_i & last_s;
    end

    // Row count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clear_i) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (en_i) begin
            if (last_s) begin
                cnt_r <= {WIDTH{1'b0}};
            end else begin
                cnt_r <= cnt_r + WIDTH'(1);
            end
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/redmule_zbuf_sched.sv
// redmule_zbuf_sched
// Schedules the RedMulE Z-buffer: counts engine rows into the buffer
// (FILL), then streams the tile out to the store streamer (DRAIN).
// Holds only pointers and flags, no data.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous soft clear, highest priority
//   start_i        : job start pulse (honoured only in IDLE)
//   stop_i         : job end pulse (deferred to end of tile while draining)
//   fill_i         : engine row-ready pulse
//   store_rows_i   : rows to store for this tile (0 means DEPTH)
//   z_ready_i      : streamer ready
//   z_valid_o      : store beat valid (registered)
//   wr_ptr_o       : buffer write row
//   rd_ptr_o       : buffer read row
//   full_o         : buffer full (high throughout DRAIN)
//   empty_o        : one-cycle pulse after the last beat of a tile
//   clk_en_o       : buffer clock enable
//   busy_o         : job active
//   ovf_err_o      : sticky overflow error (fill_i while not filling)
module redmule_zbuf_sched
    import redmule_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             fill_i,
    input  logic [CNT_W-1:0] store_rows_i,
    input  logic             z_ready_i,
    output logic             z_valid_o,
    output logic [CNT_W-1:0] wr_ptr_o,
    output logic [CNT_W-1:0] rd_ptr_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             clk_en_o,
    output logic             busy_o,
    output logic             ovf_err_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    zbuf_state_e      state_r;
    zbuf_flgs_t       flgs_r;
    logic             z_valid_r;
    logic             clk_en_r;
    logic             busy_r;
    logic             ovf_r;
    logic             stop_lat_r;
    logic [CNT_W-1:0] eff_rows_r;

    logic [CNT_W-1:0] wr_ptr_s;
    logic [CNT_W-1:0] rd_ptr_s;
    logic             wr_en_s;
    logic             wr_clr_s;
    logic             wr_wrap_s;
    logic             rd_en_s;
    logic             rd_last_s;
    logic             stop_pend_s;
    logic [CNT_W-1:0] eff_next_s;

    // Counter controls: which fill pulses are accepted, handshakes, tile size.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_clr_s    = clear_i;
        rd_en_s     = (state_r == ZBUF_DRAIN) & z_valid_r & z_ready_i;
        // A stop arriving together with the last beat is treated as latched.
        stop_pend_s = stop_lat_r | stop_i;
        case (state_r)
            ZBUF_FILL: begin
                wr_en_s  = fill_i & ~stop_i;
                wr_clr_s = clear_i | stop_i;
            end
            ZBUF_DRAIN: begin
                // A row landing on the last beat starts the next tile.
                wr_en_s = fill_i & rd_last_s & ~stop_pend_s;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
        // Out-of-range row counts are clamped to a full tile.
        if ((store_rows_i == {CNT_W{1'b0}}) || (store_rows_i > DEPTH_C)) begin
            eff_next_s = DEPTH_C;
        end else begin
            eff_next_s = store_rows_i;
        end
    end

    redmule_row_counter #(
        .WIDTH (CNT_W)
    ) i_wr_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (wr_clr_s),
        .en_i    (wr_en_s),
        .limit_i (DEPTH_C),
        .cnt_o   (wr_ptr_s),
        .wrap_o  (wr_wrap_s)
    );

    redmule_row_counter #(
        .WIDTH (CNT_W)
    ) i_rd_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .en_i    (rd_en_s),
        .limit_i (eff_rows_r),
        .cnt_o   (rd_ptr_s),
        .wrap_o  (rd_last_s)
    );

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ZBUF_IDLE;
            flgs_r     <= '{full: 1'b0, empty: 1'b0};
            z_valid_r  <= 1'b0;
            clk_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
            stop_lat_r <= 1'b0;
            eff_rows_r <= DEPTH_C;
        end else if (clear_i) begin
            state_r    <= ZBUF_IDLE;
            flgs_r     <= '{full: 1'b0, empty: 1'b0};
            z_valid_r  <= 1'b0;
            clk_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
            stop_lat_r <= 1'b0;
        end else begin
            flgs_r.empty <= 1'b0;
            case (state_r)
                ZBUF_IDLE: begin
                    if (start_i) begin
                        state_r  <= ZBUF_FILL;
                        clk_en_r <= 1'b1;
                        busy_r   <= 1'b1;
                        ovf_r    <= 1'b0;
                    end else if (fill_i) begin
                        ovf_r <= 1'b1;
                    end
                end
                ZBUF_FILL: begin
                    if (stop_i) begin
                        state_r  <= ZBUF_IDLE;
                        clk_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else if (wr_wrap_s) begin
                        state_r     <= ZBUF_DRAIN;
                        flgs_r.full <= 1'b1;
                        z_valid_r   <= 1'b1;
                        eff_rows_r  <= eff_next_s;
                    end
                end
                ZBUF_DRAIN: begin
                    if (fill_i && !wr_en_s) begin
                        ovf_r <= 1'b1;
                    end
                    if (stop_i) begin
                        stop_lat_r <= 1'b1;
                    end
                    if (rd_last_s) begin
                        flgs_r.full  <= 1'b0;
                        flgs_r.empty <= 1'b1;
                        z_valid_r    <= 1'b0;
                        stop_lat_r   <= 1'b0;
                        if (stop_pend_s) begin
                            state_r  <= ZBUF_IDLE;
                            clk_en_r <= 1'b0;
                            busy_r   <= 1'b0;
                        end else begin
                            state_r <= ZBUF_FILL;
                        end
                    end
                end
                default: begin
                    state_r   <= ZBUF_IDLE;
                    z_valid_r <= 1'b0;
                    clk_en_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign z_valid_o = z_valid_r;
    assign wr_ptr_o  = wr_ptr_s;
    assign rd_ptr_o  = rd_ptr_s;
    assign full_o    = flgs_r.full;
    assign empty_o   = flgs_r.empty;
    assign clk_en_o  = clk_en_r;
    assign busy_o    = busy_r;
    assign ovf_err_o = ovf_r;

endmodule

// File: doc/redmule_zbuf_sched.md
REDMULE_ZBUF_SCHED -- requirements
Module: redmule_zbuf_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning Z-buffer rows (one per array column).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH+1), meaning the row-counter width.
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- start_i  in  1  job start pulse
- stop_i  in  1  job end pulse (last tile stored)
- fill_i  in  1  engine row-ready pulse
- store_rows_i  in  CNT_W  rows to store this tile (0 = DEPTH)
- z_ready_i  in  1  streamer ready
- z_valid_o  out  1  store beat valid
- wr_ptr_o  out  CNT_W  buffer write row
- rd_ptr_o  out  CNT_W  buffer read row
- full_o  out  1  buffer full
- empty_o  out  1  tile drained, 1-cycle pulse
- clk_en_o  out  1  buffer clock enable
- busy_o  out  1  job active
- ovf_err_o  out  1  sticky overflow error

Function
REQ-004 SHALL implement states IDLE, FILL, DRAIN.
REQ-005 IDLE: outputs low, pointers 0; start_i -> FILL next cycle.
REQ-006 FILL: each fill_i increments wr_ptr_o by 1; clk_en_o = 1.
REQ-007 FILL: fill_i with wr_ptr_o == DEPTH-1 -> wr_ptr_o = 0, full_o = 1, state DRAIN on the next edge.
REQ-008 FILL: full_o SHALL be registered, high for every DRAIN cycle and low elsewhere.
REQ-009 DRAIN: z_valid_o = 1 and clk_en_o = 1 while rd_ptr_o < effective rows.
- Effective rows = store_rows_i, or DEPTH when store_rows_i is 0, sampled on the FILL->DRAIN edge.
REQ-010 Beat handshake: z_valid_o & z_ready_i increments rd_ptr_o; z_valid_o SHALL NOT drop without a handshake.
REQ-011 Last beat accepted -> rd_ptr_o = 0, empty_o pulses 1 cycle in the following cycle, state FILL.
REQ-012 stop_i in FILL or IDLE -> IDLE next cycle; stop_i in DRAIN SHALL be latched and honoured after REQ-011 (DRAIN -> IDLE).
REQ-013 fill_i in DRAIN or IDLE SHALL be dropped and SHALL set ovf_err_o, which clears only on clear_i, start_i or reset.
REQ-014 fill_i coincident with the last DRAIN handshake SHALL count as the first FILL row (wr_ptr_o = 1).
REQ-015 start_i outside IDLE SHALL be ignored.
REQ-016 busy_o = 1 in FILL and DRAIN.
REQ-017 clear_i has priority over every other input: next cycle IDLE, pointers 0, all flags 0, latched stop cleared.
REQ-018 z_valid_o SHALL be a registered/state-derived output with no combinational path from z_ready_i.

Reset
REQ-019 rst_ni low SHALL force IDLE, wr_ptr_o = rd_ptr_o = 0, and all 1-bit outputs 0 asynchronously.
REQ-020 Reset mid-DRAIN SHALL abandon the tile with no empty_o pulse.

Structure
REQ-021 The state enum and a zbuf_flgs_t struct (full, empty) SHALL live in redmule_pkg.
REQ-022 The block SHALL instantiate one sub-module, redmule_row_counter (wrap-at-limit up-counter with clear/enable), twice: write side and read side.
REQ-023 The block SHALL contain no datapath storage, only pointers and flags.

Verification
REQ-024 start; 8 fill_i; store_rows_i = 0, z_ready_i = 1 -> full_o 1 cycle after 8th fill; 8 beats rd_ptr 0..7; empty_o pulse; state FILL.
REQ-025 store_rows_i = 3, z_ready_i toggling every cycle -> exactly 3 beats; z_valid_o held through stalls; empty_o after 3rd handshake.
REQ-026 fill_i during DRAIN -> ovf_err_o = 1 and wr_ptr_o unchanged; next start_i clears ovf_err_o.
REQ-027 stop_i at 2nd DRAIN beat of 8 -> all 8 beats complete; empty_o pulse; then IDLE with busy_o = 0.
REQ-028 clear_i at 4th DRAIN beat -> next cycle IDLE, pointers 0, z_valid_o 0, no empty_o.
REQ-029 rst_ni asserted mid-FILL (wr_ptr_o = 5) -> all outputs 0 immediately; start_i after release restarts with wr_ptr_o = 0.
